pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a five-stage pipeline: start-up flush sequence,
// memory-wait freeze, branch/jump flushes, load-use stalls and two saturating counters.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        id_jump,
  input  logic        mem_busy,
  input  logic        clear_counters,
  output logic        pc_enable,
  output logic        ifid_enable,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_freeze,
  output logic [1:0]  state_out,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] init_cnt;
  logic       load_use;
  logic       stall_now;
  logic       flush_now;

  // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

  assign state_out = state;

  // Priority outside INIT: memory wait, branch flush, load-use stall, jump flush, run.
  // WAIT with mem_busy low already behaves like RUN for this cycle.
  always_comb begin
    pc_enable   = 1'b0;
    ifid_enable = 1'b1;
    ifid_flush  = 1'b1;
    idex_flush  = 1'b1;
    pipe_freeze = 1'b0;
    stall_now   = 1'b0;
    flush_now   = 1'b0;
    if (state != ST_INIT) begin
      if (mem_busy) begin
        ifid_enable = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b1;
        stall_now   = 1'b1;
      end else if (ex_branch_taken) begin
        pc_enable = 1'b1;
        flush_now = 1'b1;
      end else if (load_use) begin
        ifid_enable = 1'b0;
        ifid_flush  = 1'b0;
        stall_now   = 1'b1;
      end else if (id_jump) begin
        pc_enable  = 1'b1;
        idex_flush = 1'b0;
        flush_now  = 1'b1;
      end else begin
        pc_enable  = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= 2'd0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == 2'd1) begin
            state    <= ST_RUN;
            init_cnt <= 2'd0;
          end else begin
            init_cnt <= init_cnt + 2'd1;
          end
        end
        ST_RUN, ST_WAIT: state <= mem_busy ? ST_WAIT : ST_RUN;
        default:         state <= ST_INIT;
      endcase
    end
  end

  // stall_now/flush_now are never set in INIT, so start-up cycles are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else if (clear_counters) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (stall_now && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (flush_now && (flush_count != 16'hFFFF))  flush_count  <= flush_count + 16'd1;
    end
  end

endmodule
